// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC and sequences instruction fetch over a req/ack memory port and a valid/ready decode port.
// Optional exception entry (EXC/EPC ports, EXC_VECTOR) is compiled in with `define PC_SEQ_EXC_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h00400000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_target,
`ifdef PC_SEQ_EXC_EN
    input  logic        i_exc,
    output logic [31:0] o_epc,
`endif
    output logic [31:0] o_pc
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DRAIN} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pending;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_req;
    logic        r_valid;
    logic        w_take;
    logic [31:0] w_tgt;

`ifdef PC_SEQ_EXC_EN
    localparam logic [31:0] EXC_VECTOR = 32'h80000180;
    logic        w_exc;
    logic [31:0] r_epc;
    // Exceptions are only recognised once fetching has started; EXC outranks REDIRECT.
    assign w_exc  = i_exc && (r_state != IDLE);
    assign w_tgt  = w_exc ? EXC_VECTOR : (i_redirect_target & ~32'h3);
    assign w_take = w_exc || i_redirect;
    assign o_epc  = r_epc;
`else
    assign w_tgt  = i_redirect_target & ~32'h3;
    assign w_take = i_redirect;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_pc       <= RESET_VECTOR;
            r_pending  <= '0;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
`ifdef PC_SEQ_EXC_EN
            r_epc      <= '0;
`endif
        end else begin
`ifdef PC_SEQ_EXC_EN
            if (w_exc)
                r_epc <= (r_state == ISSUE) ? r_instr_pc : r_pc;
`endif
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                    r_req   <= 1'b1;
                    if (w_take)
                        r_pc <= w_tgt;
                end
                FETCH: begin
                    if (w_take && i_imem_ack) begin
                        r_pc <= w_tgt;
                    end else if (w_take) begin
                        // Address must stay put until the in-flight request is acked.
                        r_pending <= w_tgt;
                        r_state   <= DRAIN;
                    end else if (i_imem_ack) begin
                        r_instr    <= i_imem_rdata;
                        r_instr_pc <= r_pc;
                        r_req      <= 1'b0;
                        r_valid    <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_take || i_instr_ready) begin
                        r_pc    <= w_take ? w_tgt : r_pc + 32'd4;
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (w_take)
                        r_pending <= w_tgt;
                    if (i_imem_ack) begin
                        r_pc    <= w_take ? w_tgt : r_pending;
                        r_state <= FETCH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_imem_req    = r_req;
    assign o_imem_addr   = r_pc;
    assign o_instr_valid = r_valid;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_pc          = r_pc;
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller that owns the MIPS program counter and sequences instruction fetch. It issues word-aligned requests to instruction memory over a req/ack handshake and presents each fetched instruction to decode over a valid/ready handshake. It applies control-flow redirects from execute, squashing wrong-path work. It sits between the instruction memory port and the decode stage, replacing free-running PC increment with a handshake-aware, stall-tolerant sequencer.

## Interface
- RESET_VECTOR, 32'h00400000, PC value loaded on reset.
- EXC_VECTOR, 32'h80000180, exception handler entry; used only with PC_SEQ_EXC_EN.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- IMEM_REQ  out  1  fetch request, held until IMEM_ACK.
- IMEM_ADDR  out  32  fetch address (= PC); stable while IMEM_REQ=1.
- IMEM_ACK  in  1  memory accepted the request and returns data this cycle.
- IMEM_RDATA  in  32  instruction word, valid when IMEM_ACK=1.
- INSTR_VALID  out  1  INSTR/INSTR_PC valid for decode.
- INSTR_READY  in  1  decode consumes the instruction when INSTR_VALID&INSTR_READY.
- INSTR  out  32  fetched instruction word.
- INSTR_PC  out  32  address of INSTR.
- REDIRECT  in  1  one-cycle pulse: take REDIRECT_TARGET as next PC.
- REDIRECT_TARGET  in  32  branch/jump/jr target; bits [1:0] ignored (forced to 0).
- PC  out  32  current PC register.
- EXC  in  1  exception pulse; present only with PC_SEQ_EXC_EN.
- EPC  out  32  captured exception PC; present only with PC_SEQ_EXC_EN.

## Operation
- States: IDLE, FETCH, ISSUE, DRAIN.
- IDLE: entered on reset; next cycle goes to FETCH (one dead cycle after reset release).
- FETCH: IMEM_REQ=1, IMEM_ADDR=PC. On IMEM_ACK: INSTR<=IMEM_RDATA, INSTR_PC<=PC, go to ISSUE.
- ISSUE: INSTR_VALID=1. On INSTR_READY: PC<=PC+4, go to FETCH.
- DRAIN: request in flight is wrong-path. Hold IMEM_REQ=1, IMEM_ADDR unchanged until IMEM_ACK, discard IMEM_RDATA, then go to FETCH with PC<=pending target.
- Redirect handling (priority EXC > REDIRECT > sequential):
  - In IDLE: PC<=target.
  - In FETCH without ACK: latch target into pending register, go to DRAIN.
  - In FETCH with ACK: discard data, PC<=target, go to FETCH.
  - In ISSUE: PC<=target, go to FETCH. INSTR_VALID drops next cycle; if INSTR_READY is high the same cycle, the instruction counts as consumed.
  - In DRAIN: the newer target overwrites the pending one.
- Arithmetic: PC+4 modulo 2^32; 32'hFFFFFFFC wraps to 32'h00000000. PC[1:0] is always 0.
- Reset values: PC=RESET_VECTOR, state IDLE, IMEM_REQ=0, INSTR_VALID=0, INSTR=0, INSTR_PC=0, pending=0, EPC=0.
- Reset asserted mid-operation: immediate return to the reset values; an outstanding fetch is abandoned and memory must tolerate the dropped IMEM_REQ.

## Timing
- IMEM_ACK in cycle k -> INSTR_VALID=1 in cycle k+1 (registered outputs only).
- Zero-wait memory with READY always high: one instruction every 2 cycles.
- Handoff in cycle k -> IMEM_REQ for the next PC in cycle k+1.
- Redirect in cycle k, no request in flight -> IMEM_ADDR=target in cycle k+1.
- Redirect while a fetch is in flight -> target fetched the cycle after the stale ACK.
- No combinational path from any input to any output.

## Configuration
- PC_SEQ_EXC_EN defined:
  - EXC and EPC ports exist.
  - EXC in any non-IDLE state: EPC<=INSTR_PC if in ISSUE, else EPC<=PC. Then redirect to EXC_VECTOR using the same squash/drain rules.
  - EXC beats a REDIRECT in the same cycle.
- PC_SEQ_EXC_EN undefined: ports, EPC register and vector logic are absent; behaviour is otherwise identical.

## Test plan
- Reset then zero-wait memory, READY=1 -> IMEM_ADDR 0x00400000, 0x00400004, 0x00400008 on cycles 1, 3, 5 after reset release; INSTR_PC matches each.
- Memory ACK delayed 3 cycles, READY held low 2 cycles -> IMEM_ADDR stable through the wait; INSTR stable until consumed; no address skipped.
- REDIRECT to 0x00400103 during ISSUE -> next IMEM_ADDR=0x00400100; the squashed instruction is never consumed.
- REDIRECT to 0x00401000 during FETCH with ACK pending 2 cycles -> stale data discarded, INSTR_VALID stays low, next request at 0x00401000.
- PC forced to 0xFFFFFFFC via redirect and consumed -> next IMEM_ADDR=0x00000000.
- With PC_SEQ_EXC_EN: EXC and REDIRECT together in ISSUE at INSTR_PC 0x00400010 -> EPC=0x00400010, next IMEM_ADDR=0x80000180. RST low mid-DRAIN -> all outputs return to reset values immediately.
